uart_rx: RTL
============

# uart_rx

UART receive stage that consumes the 16x oversampling tick from the baud generator and turns the serial `rx_i` line into parallel bytes. It synchronises the line, validates the start bit, majority-votes each bit at mid-period, and checks parity and stop bits. It presents each frame on a valid/ready holding register to the APB register block. Frame format is configured at run time: 5–8 data bits, optional parity, and 1 or 2 stop bits.

## Interface
- `OVERSAMPLE`, 16, sample ticks per bit; must be even and ≥8.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `tick_rx_i`  in  1  oversampling tick, toggling level. Every transition, rising or falling, is one sample tick.
- `rx_i`  in  1  asynchronous serial line; idle high.
- `data_bits_i`  in  2  data bits per frame: 00=5, 01=6, 10=7, 11=8.
- `parity_en_i`  in  1  1 = parity bit present.
- `parity_odd_i`  in  1  1 = odd parity, 0 = even parity.
- `stop_bits_i`  in  1  0 = one stop bit, 1 = two stop bits.
- `rx_ready_i`  in  1  consumer accepts the held byte.
- `rx_data_o`  out  8  received byte, LSB first on the line, right-aligned, unused MSBs 0.
- `rx_valid_o`  out  1  held byte available.
- `parity_err_o`  out  1  parity mismatch on the held frame.
- `frame_err_o`  out  1  a stop bit was sampled 0 on the held frame.
- `overrun_err_o`  out  1  a frame completed while `rx_valid_o` was still high.

## Operation
- `rx_i` passes through a 2-flop synchroniser, giving `rx_s`.
- Tick detect: `tick_q` registers `tick_rx_i`. `tick = tick_q ^ tick_rx_i` is a 1-cycle strobe.
- Sample counter `scnt`, width clog2(OVERSAMPLE), advances only on `tick`.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - A falling edge on `rx_s` clears `scnt` and moves to START.
  - The configuration inputs are latched at this point and stay frozen for the whole frame.
- Bit decision (all non-IDLE states):
  - Samples are taken at `scnt` = OVERSAMPLE/2−1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The bit value is the majority of the three, decided at the third sample.
  - The bit period ends when `scnt` wraps from OVERSAMPLE−1 to 0.
- START:
  - If the majority is 1, this is a false start: go to IDLE immediately and produce no output.
  - Otherwise stay until the wrap, then go to DATA.
- DATA:
  - Shift in latched-N bits, LSB first, with a bit index 0..N−1.
  - After the last bit, go to PARITY if parity is enabled, else STOP.
- PARITY:
  - Expected parity bit = XOR of the data bits, inverted if `parity_odd`.
  - A mismatch sets the internal parity flag.
- STOP:
  - Any stop sample of 0 sets the internal frame flag.
  - With 2 stop bits, the first stop bit runs a full period, then the second is decided.
  - On the final stop decision: commit the frame and go to IDLE without waiting for the period end. This allows back-to-back frames.
- Commit:
  - Load `rx_data_o` and the error flags, and set `rx_valid_o`.
  - If `rx_valid_o` was already high and is not being accepted in the same cycle, overwrite and set `overrun_err_o`.
- Handshake: `rx_valid_o && rx_ready_i` clears `rx_valid_o` and all three error outputs.
- Commit and accept in the same cycle: the new frame wins. `rx_valid_o` stays 1, flags take the new values, and overrun is not set.
- Break (all zeros): commits `rx_data_o`=0 with `frame_err_o`=1.

## Timing
- Reset values: `rx_valid_o`=0, `rx_data_o`=0, all error outputs 0, FSM in IDLE.
- Internal reset values: `tick_q`=0, synchroniser flops=1.
- Reset mid-frame aborts the frame with no commit.
- Sync latency: `rx_i` reaches `rx_s` after 2 `clk`.
- Commit latency: outputs are registered and change on the clock after the final stop decision strobe.
- Tick strobes are assumed at least 2 `clk` apart. The block holds no state across ticks beyond `scnt`.
- `tick_rx_i` stuck at one level freezes the FSM mid-frame, with no timeout.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum `rx_state_e`,
  - the `data_bits` encoding and a function `data_len(sel)` returning 5..8,
  - the `OVERSAMPLE` default.
- One sub-module, `uart_rx_sync`: the 2-flop synchroniser plus the falling-edge detect.

## Test plan
Common setup: 100 MHz clock, `tick_rx_i` toggling every 54 clk (115200 baud, bit = 864 clk).

1. Basic frame, 8N1, byte 0xA5 → single commit, `rx_data_o`=0xA5, `rx_valid_o`=1, all errors 0. Assert `rx_ready_i` → `rx_valid_o`=0 next clk.
2. 7E2 frames:
   - Byte 0x41 with correct even parity → 0x41, no error.
   - Same frame with the parity bit flipped → `parity_err_o`=1.
   - 5O1 byte 0x1F → `rx_data_o`=0x1F.
3. 300-clk low glitch while idle → false start, no commit, FSM back in IDLE.
4. 8N1 frame with the stop bit forced 0, and an all-zero break → `frame_err_o`=1. The break gives `rx_data_o`=0x00.
5. Two frames 0x11 then 0x22 back to back, `rx_ready_i`=0 → `rx_data_o`=0x22, `overrun_err_o`=1. Repeat with `rx_ready_i` pulsed on the second commit clk → `overrun_err_o`=0.
6. Robustness:
   - `reset` pulsed mid-data-bit → all outputs 0, no commit.
   - A following clean 0x5A is received correctly.
   - A 1-tick noise spike inside a data bit is rejected by the majority vote.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, frame configuration and data-length decode.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    DBITS_5 = 2'b00,
    DBITS_6 = 2'b01,
    DBITS_7 = 2'b10,
    DBITS_8 = 2'b11
  } data_bits_e;

  typedef struct packed {
    logic [1:0] data_bits;
    logic       parity_en;
    logic       parity_odd;
    logic       stop_bits;
  } rx_cfg_t;

  function automatic logic [3:0] data_len(input logic [1:0] sel);
    case (data_bits_e'(sel))
      DBITS_5: return 4'd5;
      DBITS_6: return 4'd6;
      DBITS_7: return 4'd7;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line plus a falling-edge strobe on the synchronised value.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx_i,
  output logic rx_s,
  output logic fall_c
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Flops reset to the idle-high line level so reset never fakes a start edge
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      prev_q <= sync_q[1];
    end
  end

  assign rx_s   = sync_q[1];
  assign fall_c = prev_q & ~sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled majority-vote bit recovery with run-time frame format and a valid/ready holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_rx_i,
  input  logic       rx_i,
  input  logic [1:0] data_bits_i,
  input  logic       parity_en_i,
  input  logic       parity_odd_i,
  input  logic       stop_bits_i,
  input  logic       rx_ready_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       overrun_err_o
);

  localparam int unsigned SCNT_W = $clog2(OVERSAMPLE);
  localparam logic [SCNT_W-1:0] SMP0  = SCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SCNT_W-1:0] SMP1  = SCNT_W'(OVERSAMPLE / 2);
  localparam logic [SCNT_W-1:0] SMP2  = SCNT_W'(OVERSAMPLE / 2 + 1);
  localparam logic [SCNT_W-1:0] SLAST = SCNT_W'(OVERSAMPLE - 1);

  rx_state_e         state_q, state_d;
  rx_cfg_t           cfg_q;
  logic              rx_s, fall_c;
  logic              tick_q;
  logic [SCNT_W-1:0] scnt_q;
  logic [1:0]        samp_q;
  logic [2:0]        bit_idx_q;
  logic              stop_idx_q;
  logic [7:0]        shreg_q;
  logic              par_flag_q, frame_flag_q;

  logic tick_c, decide_c, wrap_c, maj_c, last_bit_c, final_stop_c;
  logic start_c, shift_c, next_bit_c, par_chk_c, stop_chk_c, next_stop_c, commit_c;

  uart_rx_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .rx_i   (rx_i),
    .rx_s   (rx_s),
    .fall_c (fall_c)
  );

  assign tick_c       = tick_q ^ tick_rx_i;
  assign decide_c     = tick_c && (scnt_q == SMP2);
  assign wrap_c       = tick_c && (scnt_q == SLAST);
  assign maj_c        = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
  assign last_bit_c   = bit_idx_q == 3'(data_len(cfg_q.data_bits) - 4'd1);
  assign final_stop_c = !cfg_q.stop_bits || stop_idx_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= RX_IDLE;
    else       state_q <= state_d;
  end

  // Next state and per-cycle datapath strobes
  always_comb begin
    state_d     = state_q;
    start_c     = 1'b0;
    shift_c     = 1'b0;
    next_bit_c  = 1'b0;
    par_chk_c   = 1'b0;
    stop_chk_c  = 1'b0;
    next_stop_c = 1'b0;
    commit_c    = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (fall_c) begin
          start_c = 1'b1;
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (decide_c && maj_c) state_d = RX_IDLE;
        else if (wrap_c)       state_d = RX_DATA;
      end
      RX_DATA: begin
        shift_c = decide_c;
        if (wrap_c) begin
          if (last_bit_c) state_d = cfg_q.parity_en ? RX_PARITY : RX_STOP;
          else            next_bit_c = 1'b1;
        end
      end
      RX_PARITY: begin
        par_chk_c = decide_c;
        if (wrap_c) state_d = RX_STOP;
      end
      RX_STOP: begin
        stop_chk_c = decide_c;
        // The last stop bit commits at its decision point, freeing the line for the next start
        if (decide_c && final_stop_c) begin
          commit_c = 1'b1;
          state_d  = RX_IDLE;
        end else if (wrap_c) begin
          next_stop_c = 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q       <= 1'b0;
      scnt_q       <= '0;
      samp_q       <= '0;
      cfg_q        <= '0;
      bit_idx_q    <= '0;
      stop_idx_q   <= 1'b0;
      shreg_q      <= '0;
      par_flag_q   <= 1'b0;
      frame_flag_q <= 1'b0;
    end else begin
      tick_q <= tick_rx_i;
      if (start_c)     scnt_q <= '0;
      else if (tick_c) scnt_q <= (scnt_q == SLAST) ? '0 : scnt_q + SCNT_W'(1);
      if (tick_c && scnt_q == SMP0) samp_q[0] <= rx_s;
      if (tick_c && scnt_q == SMP1) samp_q[1] <= rx_s;
      if (start_c) begin
        cfg_q        <= '{data_bits: data_bits_i, parity_en: parity_en_i,
                          parity_odd: parity_odd_i, stop_bits: stop_bits_i};
        bit_idx_q    <= '0;
        stop_idx_q   <= 1'b0;
        shreg_q      <= '0;
        par_flag_q   <= 1'b0;
        frame_flag_q <= 1'b0;
      end
      if (shift_c)              shreg_q[bit_idx_q] <= maj_c;
      if (next_bit_c)           bit_idx_q <= bit_idx_q + 3'd1;
      if (par_chk_c)            par_flag_q <= maj_c ^ (^shreg_q) ^ cfg_q.parity_odd;
      if (stop_chk_c && !maj_c) frame_flag_q <= 1'b1;
      if (next_stop_c)          stop_idx_q <= 1'b1;
    end
  end

  // Holding register: a new frame overrides a same-cycle accept
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data_o     <= '0;
      rx_valid_o    <= 1'b0;
      parity_err_o  <= 1'b0;
      frame_err_o   <= 1'b0;
      overrun_err_o <= 1'b0;
    end else if (commit_c) begin
      rx_data_o     <= shreg_q;
      rx_valid_o    <= 1'b1;
      parity_err_o  <= par_flag_q;
      frame_err_o   <= frame_flag_q | ~maj_c;
      overrun_err_o <= rx_valid_o & ~rx_ready_i;
    end else if (rx_valid_o && rx_ready_i) begin
      rx_valid_o    <= 1'b0;
      parity_err_o  <= 1'b0;
      frame_err_o   <= 1'b0;
      overrun_err_o <= 1'b0;
    end
  end

endmodule
